// File: rtl/mandel_pixel_scheduler.sv
// Mandelbrot frame scheduler: raster-order pixel dispatch to an engine pool, result capture, framebuffer writes.
// Define MANDEL_SCHED_PERF_EN to build the frame-duration counter behind o_frame_cycles.

module mandel_pixel_scheduler #(
  parameter int H_RES   = 800,
  parameter int V_RES   = 600,
  parameter int NUM_ENG = 4,
  parameter int ADDR_W  = 20
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_frame_done,
  output logic [NUM_ENG-1:0]        o_eng_start,
  output logic signed [15:0]        o_eng_x,
  output logic signed [15:0]        o_eng_y,
  input  logic [NUM_ENG-1:0]        i_eng_done,
  input  logic [NUM_ENG*24-1:0]     i_eng_rgb,
  output logic                      o_wr_en,
  output logic [ADDR_W-1:0]         o_wr_addr,
  output logic [23:0]               o_wr_rgb,
  input  logic                      i_wr_ready,
  output logic [31:0]               o_frame_cycles
);

  localparam int SLOT_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [1:0] {SLOT_FREE, SLOT_BUSY, SLOT_HELD} slot_t;

  state_t              state, state_nxt;
  slot_t               slot_st   [NUM_ENG];
  logic [ADDR_W-1:0]   slot_addr [NUM_ENG];
  logic [23:0]         slot_rgb  [NUM_ENG];
  logic [15:0]         x_cnt, y_cnt;
  logic [SLOT_W-1:0]   wr_slot, wr_idx;
  logic [NUM_ENG-1:0]  free_oh;
  logic                all_free, wr_vld, wr_acc, wr_load, start_acc, last_pix, dispatch;
  logic [ADDR_W-1:0]   disp_addr;

  assign start_acc = (state == S_IDLE) && i_start;
  assign last_pix  = (x_cnt == 16'(H_RES - 1)) && (y_cnt == 16'(V_RES - 1));
  assign disp_addr = ADDR_W'(32'(y_cnt) * 32'(H_RES) + 32'(x_cnt));
  assign wr_acc    = o_wr_en && i_wr_ready;
  assign wr_load   = !o_wr_en || i_wr_ready;

  // Walk downward so the lowest-index FREE / HELD slot wins; the slot already
  // sitting in the write register is not a candidate for the next load.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    free_oh  = '0;
    all_free = 1'b1;
    wr_vld   = 1'b0;
    wr_idx   = '0;
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      if (slot_st[k] == SLOT_FREE) begin
        free_oh    = '0;
        free_oh[k] = 1'b1;
      end else begin
        all_free = 1'b0;
      end
      if (slot_st[k] == SLOT_HELD && !(o_wr_en && wr_slot == SLOT_W'(k))) begin
        wr_vld = 1'b1;
        wr_idx = SLOT_W'(k);
      end
    end
  end

  assign o_eng_start  = (state == S_RUN) ? free_oh : '0;
  assign dispatch     = |o_eng_start;
  assign o_eng_x      = dispatch ? x_cnt : '0;
  assign o_eng_y      = dispatch ? y_cnt : '0;
  assign o_busy       = (state == S_RUN) || (state == S_DRAIN);
  assign o_frame_done = (state == S_DONE);

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start)             state_nxt = S_RUN;
      S_RUN:   if (dispatch && last_pix) state_nxt = S_DRAIN;
      S_DRAIN: if (all_free)            state_nxt = S_DONE;
      S_DONE:                           state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || start_acc) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (dispatch) begin
      if (x_cnt == 16'(H_RES - 1)) begin
        x_cnt <= '0;
        y_cnt <= last_pix ? 16'd0 : y_cnt + 16'd1;
      end else begin
        x_cnt <= x_cnt + 16'd1;
      end
    end
  end

  // A done pulse on a non-BUSY slot falls through the case and is dropped.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_ENG; k++) begin
      if (i_rst) begin
        slot_st[k] <= SLOT_FREE;
      end else begin
        case (slot_st[k])
          SLOT_FREE: if (o_eng_start[k])                        slot_st[k] <= SLOT_BUSY;
          SLOT_BUSY: if (i_eng_done[k])                         slot_st[k] <= SLOT_HELD;
          SLOT_HELD: if (wr_acc && wr_slot == SLOT_W'(k))       slot_st[k] <= SLOT_FREE;
          default:                                              slot_st[k] <= SLOT_FREE;
        endcase
      end
    end
  end

  // NOTE: slot payload storage has no reset; the slot state alone decides whether it is meaningful.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NUM_ENG; k++) begin
      if (o_eng_start[k])                            slot_addr[k] <= disp_addr;
      if (slot_st[k] == SLOT_BUSY && i_eng_done[k])  slot_rgb[k]  <= i_eng_rgb[24*k +: 24];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_rgb  <= '0;
      wr_slot   <= '0;
    end else if (wr_load) begin
      o_wr_en <= wr_vld;
      if (wr_vld) begin
        o_wr_addr <= slot_addr[wr_idx];
        o_wr_rgb  <= slot_rgb[wr_idx];
        wr_slot   <= wr_idx;
      end
    end
  end

`ifdef MANDEL_SCHED_PERF_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_cnt        <= '0;
      o_frame_cycles <= '0;
    end else begin
      if (start_acc)   cyc_cnt <= '0;
      else if (o_busy) cyc_cnt <= cyc_cnt + 32'd1;
      if (start_acc)             o_frame_cycles <= '0;
      else if (state == S_DONE)  o_frame_cycles <= cyc_cnt;
    end
  end
`else
  assign o_frame_cycles = '0;
`endif

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Scoreboard bench for mandel_pixel_scheduler on a 4x2 frame with two modelled engines.
// Covers reset, raster dispatch, out-of-order completion, write back-pressure, mid-frame reset, frame counter.

module tb_mandel_pixel_scheduler;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = 2;
  localparam int AW = 3;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_start = 1'b0;
  logic                 i_wr_ready = 1'b0;
  logic                 o_busy, o_frame_done, o_wr_en;
  logic [N-1:0]         o_eng_start;
  logic signed [15:0]   o_eng_x, o_eng_y;
  logic [N-1:0]         i_eng_done;
  logic [N-1:0]         eng_done_m = '0;
  logic [N-1:0]         stray = '0;
  logic [N*24-1:0]      i_eng_rgb = '0;
  logic [AW-1:0]        o_wr_addr;
  logic [23:0]          o_wr_rgb;
  logic [31:0]          o_frame_cycles;

  assign i_eng_done = eng_done_m | stray;

  mandel_pixel_scheduler #(.H_RES(H), .V_RES(V), .NUM_ENG(N), .ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .o_busy(o_busy),
    .o_frame_done(o_frame_done), .o_eng_start(o_eng_start), .o_eng_x(o_eng_x),
    .o_eng_y(o_eng_y), .i_eng_done(i_eng_done), .i_eng_rgb(i_eng_rgb),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_rgb(o_wr_rgb),
    .i_wr_ready(i_wr_ready), .o_frame_cycles(o_frame_cycles)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { int addr; logic [23:0] rgb; } exp_t;

  exp_t sb[$];
  int   wr_log[$];
  bit   wr_seen [H*V];
  int   checks = 0, errors = 0;
  int   nwr = 0, ndone = 0, nbusy = 0, ndisp = 0;
  int   lat [N];
  bit   eb  [N];
  int   rem [N], ex [N], ey [N];
  int   rx = 0, ry = 0, mon_idx;
  bit   prev_hold = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [23:0]   prev_rgb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int x, input int y);
    logic [7:0] r, g, b;
    r = 8'(x * 37 + y);
    g = 8'(y * 91 + x + 5);
    b = 8'((x + 1) * (y + 3));
    return {r, g, b};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  // Engine model: reads the previous cycle's reset, captures starts, pulses done after lat[k] cycles.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      eng_done_m = '0;
      if (i_rst) begin
        for (int k = 0; k < N; k++) eb[k] = 1'b0;
        sb.delete();
      end else begin
        for (int k = 0; k < N; k++) begin
          if (eb[k]) begin
            rem[k]--;
            if (rem[k] == 0) begin
              eng_done_m[k] = 1'b1;
              i_eng_rgb[24*k +: 24] = model_rgb(ex[k], ey[k]);
              sb.push_back('{ey[k] * H + ex[k], model_rgb(ex[k], ey[k])});
              eb[k] = 1'b0;
            end
          end
        end
        for (int k = 0; k < N; k++) begin
          if (o_eng_start[k]) begin
            eb[k]  = 1'b1;
            rem[k] = lat[k];
            ex[k]  = int'(o_eng_x);
            ey[k]  = int'(o_eng_y);
          end
        end
      end
    end
  end

  // Dispatch monitor: one-hot start with raster-order coordinates.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        rx = 0;
        ry = 0;
      end else if (o_eng_start != '0) begin
        check("disp_onehot", 64'($onehot(o_eng_start)), 1);
        check("disp_x", 64'(o_eng_x), 64'(rx));
        check("disp_y", 64'(o_eng_y), 64'(ry));
        ndisp++;
        if (rx == H - 1) begin
          rx = 0;
          ry = (ry == V - 1) ? 0 : ry + 1;
        end else begin
          rx++;
        end
      end
    end
  end

  // Write monitor: scoreboard lookup, write-once, hold stability, frame pulses.
  initial begin
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("wr_hold_en", 64'(o_wr_en), 1);
          check("wr_hold_addr", 64'(o_wr_addr), 64'(prev_addr));
          check("wr_hold_rgb", 64'(o_wr_rgb), 64'(prev_rgb));
        end
        if (o_wr_en && i_wr_ready) begin
          mon_idx = -1;
          foreach (sb[i]) if (mon_idx < 0 && sb[i].addr == int'(o_wr_addr)) mon_idx = i;
          check("wr_addr_expected", 64'(mon_idx >= 0), 1);
          if (mon_idx >= 0) begin
            check("wr_rgb", 64'(o_wr_rgb), 64'(sb[mon_idx].rgb));
            sb.delete(mon_idx);
          end
          check("wr_once", 64'(wr_seen[o_wr_addr]), 0);
          wr_seen[o_wr_addr] = 1'b1;
          wr_log.push_back(int'(o_wr_addr));
          nwr++;
        end
        prev_hold = o_wr_en && !i_wr_ready;
        prev_addr = o_wr_addr;
        prev_rgb  = o_wr_rgb;
        if (o_frame_done) ndone++;
        if (o_busy)       nbusy++;
`ifndef MANDEL_SCHED_PERF_EN
        check("frame_cycles_off", 64'(o_frame_cycles), 0);
`endif
      end
    end
  end

  task automatic clear_stats();
    nwr = 0; ndone = 0; nbusy = 0; ndisp = 0;
    wr_log.delete();
    foreach (wr_seen[i]) wr_seen[i] = 1'b0;
  endtask

  task automatic start_frame();
    clear_stats();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    check("first_start", 64'(o_eng_start), 1);
    check("first_x", 64'(o_eng_x), 0);
    check("first_y", 64'(o_eng_y), 0);
  endtask

  task automatic wait_frame(input int budget);
    int c = 0;
    while (ndone == 0 && c < budget) begin
      tick(1);
      c++;
    end
    check("frame_done_seen", 64'(ndone > 0), 1);
    tick(2);
    check("frame_done_once", 64'(ndone), 1);
    check("frame_writes", 64'(nwr), H * V);
    check("sb_empty", 64'(sb.size()), 0);
    check("busy_after", 64'(o_busy), 0);
`ifdef MANDEL_SCHED_PERF_EN
    check("frame_cycles", 64'(o_frame_cycles), 64'(nbusy));
`else
    check("frame_cycles", 64'(o_frame_cycles), 0);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    // Reset for two edges with stray engine done pulses.
    lat[0] = 3; lat[1] = 3;
    stray = '1;
    tick(2);
    check("rst_busy", 64'(o_busy), 0);
    check("rst_done", 64'(o_frame_done), 0);
    check("rst_eng_start", 64'(o_eng_start), 0);
    check("rst_eng_x", 64'(o_eng_x), 0);
    check("rst_wr_en", 64'(o_wr_en), 0);
    check("rst_wr_addr", 64'(o_wr_addr), 0);
    check("rst_wr_rgb", 64'(o_wr_rgb), 0);
    check("rst_frame_cycles", 64'(o_frame_cycles), 0);
    i_rst = 1'b0;
    i_wr_ready = 1'b1;
    tick(4);
    stray = '0;
    check("idle_no_writes", 64'(nwr), 0);
    check("idle_wr_en", 64'(o_wr_en), 0);
    check("idle_busy", 64'(o_busy), 0);

    // Full frame, 3-cycle engines, always ready; a stray start mid-frame is ignored.
    start_frame();
    tick(2);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    wait_frame(200);

    // Engine 1 completes before engine 0.
    lat[0] = 6; lat[1] = 2;
    start_frame();
    wait_frame(200);
    check("ooo_first_addr", 64'(wr_log.size() > 0 ? wr_log[0] : -1), 1);

    // Back-pressure while both slots are HELD.
    lat[0] = 1; lat[1] = 1;
    i_wr_ready = 1'b0;
    start_frame();
    tick(4);
    check("bp_no_start", 64'(o_eng_start), 0);
    check("bp_wr_en", 64'(o_wr_en), 1);
    check("bp_wr_addr", 64'(o_wr_addr), 0);
    check("bp_wr_rgb", 64'(o_wr_rgb), 64'(model_rgb(0, 0)));
    tick(5);
    check("bp_no_start_late", 64'(o_eng_start), 0);
    check("bp_wr_en_late", 64'(o_wr_en), 1);
    i_wr_ready = 1'b1;
    wait_frame(200);
    check("bp_order0", 64'(wr_log.size() > 1 ? wr_log[0] : -1), 0);
    check("bp_order1", 64'(wr_log.size() > 1 ? wr_log[1] : -1), 1);

    // Reset after three dispatches with a result left HELD.
    lat[0] = 2; lat[1] = 40;
    start_frame();
    begin
      int c = 0;
      while (ndisp < 3 && c < 50) begin
        tick(1);
        c++;
      end
    end
    check("mid_three_disp", 64'(ndisp), 3);
    i_wr_ready = 1'b0;
    tick(4);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    nwr = 0;
    check("mid_rst_wr_en", 64'(o_wr_en), 0);
    check("mid_rst_busy", 64'(o_busy), 0);
    i_wr_ready = 1'b1;
    tick(4);
    check("mid_no_old_writes", 64'(nwr), 0);
    check("mid_wr_en_idle", 64'(o_wr_en), 0);
    lat[0] = 3; lat[1] = 3;
    start_frame();
    wait_frame(200);

    // Single-cycle engines; frame counter against the measured busy span.
    lat[0] = 1; lat[1] = 1;
    start_frame();
    wait_frame(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
